// File: rtl/median_pkg.sv
// Shared definitions for the median column buffer: pixel width default,
// FSM state encoding and a compile-time clog2 helper.
package median_pkg;

    localparam int PIX_W_DEF = 8;

    // Row-fill phases: the first two rows only prime the line stores.
    localparam logic [1:0] ST_FILL0  = 2'd0;
    localparam logic [1:0] ST_FILL1  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    // Address width for a store of v entries; never less than 1 bit.
    function automatic int clog2(input int v);
        int r;
        int n;
        r = 0;
        n = v - 1;
        while (n > 0) begin
            r = r + 1;
            n = n >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/line_ram.sv
// One-row line store: asynchronous read and synchronous write, so a read and a
// write to the same address in one cycle return the old contents.
module line_ram
    import median_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = PIX_W_DEF,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are deliberately not reset; the fill phases hide stale data.
    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/median_col_buf.sv
// Column buffer feeding a 3x3 median stage: emits the vertical triple
// (x,y-2),(x,y-1),(x,y) one clock after each accepted pixel once two rows are stored.
module median_col_buf
    import median_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = PIX_W_DEF,
    localparam int XW   = clog2(IMG_W),
    localparam int YW   = clog2(IMG_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    output logic [PIX_W-1:0] val_0,
    output logic [PIX_W-1:0] val_1,
    output logic [PIX_W-1:0] val_2,
    output logic [XW-1:0]    out_x,
    output logic             out_eol
);

    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [1:0]       state;

    logic             sof;
    logic [XW-1:0]    x_cur;
    logic [YW-1:0]    y_cur;
    logic [1:0]       st_cur;
    logic             x_last;
    logic             y_last;
    logic [XW-1:0]    x_nxt;
    logic [YW-1:0]    y_nxt;
    logic [1:0]       st_nxt;
    logic             accept;
    logic             emit;
    logic [PIX_W-1:0] a_rd;
    logic [PIX_W-1:0] b_rd;

    // A start-of-frame pixel resynchronises position before it is consumed.
    assign sof    = in_valid & in_sof;
    assign x_cur  = sof ? '0 : x;
    assign y_cur  = sof ? '0 : y;
    assign st_cur = sof ? ST_FILL0 : state;
    assign accept = in_valid & ~rst;
    assign emit   = in_valid & (st_cur == ST_STREAM);

    assign x_last = (x_cur == XW'(IMG_W - 1));
    assign y_last = (y_cur == YW'(IMG_H - 1));

    always_comb begin
        x_nxt  = x_cur + XW'(1);
        y_nxt  = y_cur;
        st_nxt = st_cur;
        if (x_last) begin
            x_nxt = '0;
            y_nxt = y_last ? '0 : y_cur + YW'(1);
            case (st_cur)
                ST_FILL0:  st_nxt = ST_FILL1;
                ST_FILL1:  st_nxt = ST_STREAM;
                ST_STREAM: st_nxt = y_last ? ST_FILL0 : ST_STREAM;
                default:   st_nxt = ST_FILL0;
            endcase
        end
    end

    // Line A holds row y-1; its old entry ages into line B (row y-2).
    line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line_a (
        .clk   (clk),
        .we    (accept),
        .waddr (x_cur),
        .wdata (in_pix),
        .raddr (x_cur),
        .rdata (a_rd)
    );

    line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line_b (
        .clk   (clk),
        .we    (accept),
        .waddr (x_cur),
        .wdata (a_rd),
        .raddr (x_cur),
        .rdata (b_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            state     <= ST_FILL0;
            out_valid <= 1'b0;
            val_0     <= '0;
            val_1     <= '0;
            val_2     <= '0;
            out_x     <= '0;
            out_eol   <= 1'b0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                val_0   <= b_rd;
                val_1   <= a_rd;
                val_2   <= in_pix;
                out_x   <= x_cur;
                out_eol <= x_last;
            end
            if (in_valid) begin
                x     <= x_nxt;
                y     <= y_nxt;
                state <= st_nxt;
            end
        end
    end

endmodule

// File: doc/median_col_buf.md
MEDIAN_COL_BUF -- requirements
Module: median_col_buf

Interface
REQ-001 SHALL have parameter IMG_W, default 64, giving pixels per image row (legal range 4..1024).
REQ-002 SHALL have parameter IMG_H, default 64, giving rows per frame (legal range 3..1024).
REQ-003 SHALL have parameter PIX_W, default 8, giving the pixel width in bits.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: in_pix is valid this cycle.
REQ-007 SHALL have port in_sof, input, 1 bit: start of frame, qualified by in_valid and marking pixel (0,0).
REQ-008 SHALL have port in_pix, input, PIX_W bits: raster-order pixel.
REQ-009 SHALL have port out_valid, output, 1 bit: the column triple is valid.
REQ-010 SHALL have port val_0, output, PIX_W bits: pixel at (x, y-2).
REQ-011 SHALL have port val_1, output, PIX_W bits: pixel at (x, y-1).
REQ-012 SHALL have port val_2, output, PIX_W bits: pixel at (x, y), i.e. the current input pixel.
REQ-013 SHALL have port out_x, output, clog2(IMG_W) bits: column of the emitted triple.
REQ-014 SHALL have port out_eol, output, 1 bit: the emitted triple is at x = IMG_W-1.

Function
REQ-015 SHALL keep a column counter x that increments per accepted pixel and wraps IMG_W-1 -> 0.
REQ-016 SHALL keep a row counter y that increments on each x wrap and wraps IMG_H-1 -> 0.
REQ-017 SHALL run the FSM FILL0 (y=0) -> FILL1 (y=1) -> STREAM (y>=2), returning to FILL0 when y wraps to 0.
REQ-018 SHALL hold two line stores of IMG_W entries each, line A holding row y-1 and line B holding row y-2.
REQ-019 SHALL, on each accepted pixel, read A[x] and B[x], then write B[x] <= A[x] and A[x] <= in_pix in the same cycle, with read-before-write semantics.
REQ-020 SHALL register val_0 = B[x], val_1 = A[x], val_2 = in_pix, with out_valid = 1 exactly one cycle after an accepted pixel in STREAM.
REQ-021 SHALL have a fixed latency of 1 clk from accepted pixel to output; out_valid SHALL be 0 in every cycle that follows a cycle with in_valid = 0.
REQ-022 SHALL stall completely when in_valid = 0: no counter, FSM or memory change.
REQ-023 SHALL emit exactly (IMG_H-2)*IMG_W triples per frame.
REQ-024 SHALL treat in_valid & in_sof as forcing x=0, y=0 and FILL0 before accepting the pixel, even mid-frame (resynchronisation).
REQ-025 SHALL ignore in_sof when in_valid = 0.
REQ-026 SHALL give out_x and out_eol the same 1-cycle alignment as val_*.
REQ-027 SHALL hold val_0..val_2, out_x and out_eol at their last values when out_valid = 0.

Reset
REQ-028 SHALL, while rst = 1, force x=0, y=0, FSM=FILL0, out_valid=0, val_0..val_2=0, out_x=0 and out_eol=0 on the next clk.
REQ-029 SHALL NOT clear line store contents on reset; the FILL states guarantee stale data never reaches out_valid.
REQ-030 SHALL let rst take priority over in_valid/in_sof in the same cycle, so the pixel in that cycle is dropped.

Structure
REQ-031 SHALL place PIX_W default, the FSM state encoding and a clog2 helper in a shared package, median_pkg.
REQ-032 SHALL instantiate line_ram twice: a parameterised 1-read/1-write RAM (depth IMG_W, width PIX_W) with synchronous write and read-before-write.
REQ-033 SHALL feed the median stage directly: val_0/val_1/val_2 connect port-for-port to the downstream median inputs.

Verification
REQ-034 SHALL cover this scenario: IMG_W=4, IMG_H=4, continuous valid, pixel = 16*y+x -> first out_valid 1 clk after pixel (0,2), with val_0=0x00, val_1=0x10, val_2=0x20, out_x=0; 8 triples total.
REQ-035 SHALL cover this scenario: same frame with in_valid toggling 1,0,1,0 -> identical triple sequence, out_valid low one cycle after each idle cycle.
REQ-036 SHALL cover this scenario: in_valid & in_sof asserted at pixel (2,2) -> no out_valid until row 2 of the new frame, then correct values from the new frame only.
REQ-037 SHALL cover this scenario: rst pulsed for 1 cycle mid-row 3 -> out_valid=0 and all outputs 0 next cycle; a subsequent frame from in_sof reproduces the REQ-034 result.
REQ-038 SHALL cover this scenario: back-to-back frames (frame 2 = frame 1 + 0x80) -> no triple mixes pixels from both frames; out_eol=1 exactly on out_x=3.
REQ-039 SHALL cover this scenario: IMG_W=64, random pixels, scoreboard against a reference image model -> all 3968 triples match per frame.
